// File: rtl/copro_pkg.sv
// Shared definitions for the LM32 float coprocessor master: state encoding,
// opcode field values and the canonical quiet NaN returned on timeout.
package copro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } master_state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/float_copro_master.sv
// Initiator side of the LM32 float coprocessor interface: issues one operation
// at a time, returns the result (or a timeout QNAN) on a response channel.
module float_copro_master
    import copro_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int LAT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [10:0]      req_opcode,
    input  logic [31:0]      req_op0,
    input  logic [31:0]      req_op1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_timeout,
    output logic [LAT_W-1:0] last_latency,
    output logic             copro_valid,
    output logic [10:0]      copro_opcode,
    output logic [31:0]      copro_op0,
    output logic [31:0]      copro_op1,
    input  logic             copro_complete,
    input  logic [31:0]      copro_result
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int               LAT_MAX  = (1 << LAT_W) - 1;

    master_state_e    state;
    logic [CNT_W-1:0] counter;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // the producer holds valid and its payload stable until that edge.
    // Holding off while complete is high keeps a stale completion (e.g. after
    // a reset mid-operation) from being taken as the answer to a new request.
    assign req_ready = (state == IDLE) && !copro_complete;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            copro_valid  <= 1'b0;
            copro_opcode <= '0;
            copro_op0    <= '0;
            copro_op1    <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_timeout  <= 1'b0;
            last_latency <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        copro_opcode <= req_opcode;
                        copro_op0    <= req_op0;
                        copro_op1    <= req_op1;
                        copro_valid  <= 1'b1;
                        counter      <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    counter <= counter + CNT_W'(1);
                    // Completion takes priority over a timeout in the same cycle.
                    if (copro_complete) begin
                        rsp_result  <= copro_result;
                        rsp_timeout <= 1'b0;
                        if (int'(counter) > LAT_MAX) begin
                            last_latency <= '1;
                        end else begin
                            last_latency <= LAT_W'(counter);
                        end
                        copro_valid <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (counter == CNT_LAST) begin
                        rsp_result  <= QNAN;
                        rsp_timeout <= 1'b1;
                        copro_valid <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= copro_complete ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (!copro_complete) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_copro_master.sv
// Bench for float_copro_master with a behavioural coprocessor responder and a
// response scoreboard; each scenario is a task called from one initial block.
module tb_float_copro_master;
    import copro_pkg::*;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int LAT_W          = 8;
    localparam int WAIT_MAX       = 400;

    localparam logic [31:0] F1_0   = 32'h3F80_0000;
    localparam logic [31:0] F2_0   = 32'h4000_0000;
    localparam logic [31:0] F3_0   = 32'h4040_0000;
    localparam logic [31:0] F6_0   = 32'h40C0_0000;
    localparam logic [31:0] NEG1_0 = 32'hBF80_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [10:0]      req_opcode = '0;
    logic [31:0]      req_op0 = '0;
    logic [31:0]      req_op1 = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic             rsp_timeout;
    logic [LAT_W-1:0] last_latency;
    logic             copro_valid;
    logic [10:0]      copro_opcode;
    logic [31:0]      copro_op0;
    logic [31:0]      copro_op1;
    logic             copro_complete = 1'b0;
    logic [31:0]      copro_result = '0;

    float_copro_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LAT_W(LAT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_op0(req_op0), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout), .last_latency(last_latency),
        .copro_valid(copro_valid), .copro_opcode(copro_opcode),
        .copro_op0(copro_op0), .copro_op1(copro_op1),
        .copro_complete(copro_complete), .copro_result(copro_result)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_lat      = 0;
    logic [32:0] exp_q[$];

    // Responder knobs and state.
    int stub_lat     = 2;
    int stub_div_lat = 2;
    int stub_hold    = 0;
    bit stub_hang    = 1'b0;
    int busy_cnt     = 0;
    int hold_cnt     = 0;

    // Coprocessor behaviour: a = op1, b = op0. Known vectors give true IEEE
    // results; anything else gets an asymmetric mix so operand swaps show up.
    function automatic logic [31:0] copro_model(input logic [10:0] opc,
                                                input logic [31:0] b,
                                                input logic [31:0] a);
        logic [31:0] r;
        r = {a[15:0], b[31:16]} ^ {21'd0, opc};
        case (opc[1:0])
            OP_ADD: if (a == F1_0 && b == F2_0) r = F3_0;
            OP_SUB: if (a == F1_0 && b == F2_0) r = NEG1_0;
            OP_MUL: if ((a == F2_0 && b == F3_0) || (a == F3_0 && b == F2_0)) r = F6_0;
            OP_DIV: if (a == F6_0 && b == F2_0) r = F3_0;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (!copro_valid && !copro_complete) begin
            busy_cnt <= 0;
        end else if (copro_valid && !copro_complete) begin
            if (!stub_hang &&
                busy_cnt >= ((copro_opcode[1:0] == OP_DIV) ? stub_div_lat : stub_lat)) begin
                copro_complete <= 1'b1;
                copro_result   <= copro_model(copro_opcode, copro_op0, copro_op1);
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
        end else if (copro_complete && !copro_valid) begin
            if (hold_cnt >= stub_hold) begin
                copro_complete <= 1'b0;
                hold_cnt       <= 0;
                busy_cnt       <= 0;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end
    end

    // Monitor: valid-low gap, response stability under backpressure, scoreboard.
    logic        prev_valid    = 1'b0;
    logic        prev_complete = 1'b0;
    logic        prev_stall    = 1'b0;
    logic [32:0] prev_rsp      = '0;

    always @(negedge clk) begin
        logic [32:0] exp;
        if (!reset) begin
            if (copro_valid && !prev_valid) begin
                tests_run++;
                if (prev_complete !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL valid_gap: copro_valid rose with complete=%b in accept cycle, required 0",
                             prev_complete);
                end
            end
            if (prev_stall) begin
                tests_run++;
                if (rsp_valid !== 1'b1 || {rsp_timeout, rsp_result} !== prev_rsp) begin
                    tests_failed++;
                    $display("FAIL rsp_stable: valid=%b rsp=%h, required valid=1 rsp=%h",
                             rsp_valid, {rsp_timeout, rsp_result}, prev_rsp);
                end
            end
            if (rsp_valid && rsp_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rsp_unexpected: got rsp=%h with no response pending",
                             {rsp_timeout, rsp_result});
                end else begin
                    exp = exp_q.pop_front();
                    if ({rsp_timeout, rsp_result} !== exp) begin
                        tests_failed++;
                        $display("FAIL rsp_data: got timeout=%b result=%h, required timeout=%b result=%h",
                                 rsp_timeout, rsp_result, exp[32], exp[31:0]);
                    end
                end
            end
        end
        prev_valid    = copro_valid;
        prev_complete = copro_complete;
        prev_stall    = rsp_valid && !rsp_ready && !reset;
        prev_rsp      = {rsp_timeout, rsp_result};
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_req(input logic [10:0] opc, input logic [31:0] op0,
                             input logic [31:0] op1, input logic [32:0] exp);
        int n = 0;
        req_opcode = opc;
        req_op0    = op0;
        req_op1    = op1;
        req_valid  = 1'b1;
        while (!req_ready && n < WAIT_MAX) begin
            cycles(1);
            n++;
        end
        tests_run++;
        if (!req_ready) begin
            tests_failed++;
            $display("FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        cycles(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < WAIT_MAX) begin
            cycles(1);
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || rsp_valid) begin
            tests_failed++;
            $display("FAIL drain: %0d responses pending, rsp_valid=%b, required 0 and 0",
                     exp_q.size(), rsp_valid);
            exp_q.delete();
        end
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!rsp_valid && n < WAIT_MAX) begin
            cycles(1);
            n++;
        end
        tests_run++;
        if (!rsp_valid) begin
            tests_failed++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
    endtask

    task automatic check_lat(input string name);
        tests_run++;
        if (last_latency !== LAT_W'(exp_lat)) begin
            tests_failed++;
            $display("FAIL %s: last_latency=%0d, required %0d", name, last_latency, exp_lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        tests_run++;
        if ({copro_valid, copro_opcode, copro_op0, copro_op1} !== '0) begin
            tests_failed++;
            $display("FAIL reset_copro: valid=%b opc=%h op0=%h op1=%h, required all 0",
                     copro_valid, copro_opcode, copro_op0, copro_op1);
        end
        tests_run++;
        if ({rsp_valid, rsp_timeout, rsp_result} !== '0) begin
            tests_failed++;
            $display("FAIL reset_rsp: valid=%b timeout=%b result=%h, required all 0",
                     rsp_valid, rsp_timeout, rsp_result);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
        exp_lat = 0;
        check_lat("reset_latency");
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_add();
        stub_lat  = 3;
        rsp_ready = 1'b1;
        drive_req({9'h0A5, OP_ADD}, F2_0, F1_0, {1'b0, F3_0});
        wait_drain();
        tests_run++;
        if (copro_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_valid_low: copro_valid=%b after response, required 0", copro_valid);
        end
        exp_lat = 4;
        check_lat("add_latency");
    endtask

    task automatic test_back_to_back();
        stub_lat     = 2;
        stub_div_lat = 12;
        rsp_ready    = 1'b1;
        drive_req({9'd0, OP_MUL}, F3_0, F2_0, {1'b0, F6_0});
        drive_req({9'd0, OP_DIV}, F2_0, F6_0, {1'b0, F3_0});
        exp_lat = 3;
        check_lat("mul_latency");
        wait_drain();
        exp_lat = 13;
        check_lat("div_latency");
    endtask

    task automatic test_backpressure();
        stub_lat  = 4;
        rsp_ready = 1'b0;
        drive_req({9'd0, OP_SUB}, F2_0, F1_0, {1'b0, NEG1_0});
        wait_rsp_valid();
        req_opcode = {9'd0, OP_ADD};
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== NEG1_0) begin
                tests_failed++;
                $display("FAIL stall_%0d: req_ready=%b rsp_valid=%b result=%h, required 0 1 %h",
                         i, req_ready, rsp_valid, rsp_result, NEG1_0);
            end
            cycles(1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cycles(1);
        tests_run++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stall_release: rsp_valid=%b pending=%0d, required 0 0",
                     rsp_valid, exp_q.size());
        end
        wait_drain();
        exp_lat = 5;
        check_lat("sub_latency");
    endtask

    task automatic test_timeout();
        int hi = 0;
        int n  = 0;
        stub_hang = 1'b1;
        rsp_ready = 1'b0;
        drive_req({9'd3, OP_ADD}, 32'h1234_5678, 32'h9ABC_DEF0, {1'b1, QNAN});
        while (!rsp_valid && n < WAIT_MAX) begin
            if (copro_valid) hi++;
            cycles(1);
            n++;
        end
        tests_run++;
        if (hi != TIMEOUT_CYCLES) begin
            tests_failed++;
            $display("FAIL timeout_len: issue cycles=%0d, required %0d", hi, TIMEOUT_CYCLES);
        end
        tests_run++;
        if (copro_valid !== 1'b0 || rsp_timeout !== 1'b1 || rsp_result !== QNAN) begin
            tests_failed++;
            $display("FAIL timeout_rsp: valid=%b timeout=%b result=%h, required 0 1 %h",
                     copro_valid, rsp_timeout, rsp_result, QNAN);
        end
        check_lat("timeout_latency");
        rsp_ready = 1'b1;
        wait_drain();
        stub_hang = 1'b0;
    endtask

    task automatic test_complete_vs_timeout();
        rsp_ready = 1'b1;
        stub_lat  = TIMEOUT_CYCLES - 2;
        drive_req({9'd0, OP_ADD}, F2_0, F1_0, {1'b0, F3_0});
        wait_drain();
        exp_lat = TIMEOUT_CYCLES - 1;
        check_lat("edge_latency");
        // One cycle later the timeout wins and the late completion is drained.
        stub_lat = TIMEOUT_CYCLES - 1;
        drive_req({9'd0, OP_ADD}, F2_0, F1_0, {1'b1, QNAN});
        wait_drain();
        check_lat("late_latency");
        stub_lat = 2;
    endtask

    task automatic test_reset_mid();
        stub_div_lat = 30;
        rsp_ready    = 1'b1;
        drive_req({9'd0, OP_DIV}, F2_0, F6_0, {1'b0, F3_0});
        cycles(5);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        exp_q.delete();
        tests_run++;
        if (copro_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b rsp_valid=%b req_ready=%b, required 0 0 1",
                     copro_valid, rsp_valid, req_ready);
        end
        exp_lat = 0;
        check_lat("reset_mid_latency");
        stub_lat = 2;
        drive_req({9'd0, OP_ADD}, F2_0, F1_0, {1'b0, F3_0});
        wait_drain();
        exp_lat = 3;
        check_lat("post_reset_latency");
    endtask

    task automatic test_reset_complete_high();
        stub_lat  = 2;
        stub_hold = 6;
        rsp_ready = 1'b0;
        drive_req({9'd0, OP_MUL}, F3_0, F2_0, {1'b0, F6_0});
        wait_rsp_valid();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        exp_q.delete();
        tests_run++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || copro_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: req_ready=%b rsp_valid=%b valid=%b, required 0 0 0",
                     req_ready, rsp_valid, copro_valid);
        end
        rsp_ready = 1'b1;
        drive_req({9'd0, OP_SUB}, F2_0, F1_0, {1'b0, NEG1_0});
        wait_drain();
        stub_hold = 0;
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [10:0] opc;
                    logic [31:0] a, b;
                    opc       = 11'($urandom);
                    a         = $urandom;
                    b         = $urandom;
                    stub_lat     = $urandom_range(0, 20);
                    stub_div_lat = $urandom_range(10, 40);
                    stub_hold    = $urandom_range(0, 3);
                    drive_req(opc, b, a, {1'b0, copro_model(opc, b, a)});
                end
                wait_drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    cycles(1);
                end
            end
        join
        rsp_ready = 1'b1;
        stub_hold = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(1);
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_complete_vs_timeout();
        test_reset_mid();
        test_reset_complete_high();
        test_random();
        cycles(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
